// File: rtl/gamepad_input_encoder.sv
// ---------------------------------------------------------------------------
// gamepad_input_encoder
//
// Polls a SNES-style serial gamepad once per frame and turns the 12 serial
// button bits into a packed 10-bit player input word.
//
// A free-running frame counter starts a read each time it passes 0 while the
// reader is idle. A read does three things:
//   1. It pulses pad_latch for 2*CLK_DIV cycles.
//   2. It clocks 12 bits out of the pad. Each bit is pad_clk low for CLK_DIV
//      cycles, then high for CLK_DIV cycles.
//   3. It publishes the decoded word together with a one-cycle trigger.
//
// Parameters
//   CLK_DIV      clk cycles per pad_latch / pad_clk half-phase (>= 1)
//   FRAME_PERIOD clk cycles between read starts (> 26*CLK_DIV+2)
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        synchronous, active-low reset
//   pad_data     serial button data from the pad, 0 = pressed
//   pad_latch    parallel-load strobe to the pad, active high
//   pad_clk      shift clock to the pad, idle high
//   input_data   [9] attack press, [8] right, [7] left, [6] down, [5] up,
//                [4] attack held, [3] A, [2] Start, [1] Select, [0] X
//   trigger      one-cycle pulse when input_data / pad_present update
//   pad_present  1 = the last read found a pad
//   dbg_state_o  current reader state (IDLE=0, LATCH=1, SHIFT=2, UPDATE=3)
// ---------------------------------------------------------------------------
module gamepad_input_encoder #(
   parameter int CLK_DIV      = 4,
   parameter int FRAME_PERIOD = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pad_data,
   output logic       pad_latch,
   output logic       pad_clk,
   output logic [9:0] input_data,
   output logic       trigger,
   output logic       pad_present,
   output logic [1:0] dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LATCH  = 2'd1,
      ST_SHIFT  = 2'd2,
      ST_UPDATE = 2'd3
   } state_e;

   localparam int CNT_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
   localparam int DIV_W = $clog2(2 * CLK_DIV);

   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_PERIOD - 1);
   // Last cycle of the low half of a bit (sample point), and the last
   // cycle of a whole bit (also the last cycle of the latch pulse).
   localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] BIT_LAST   = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [3:0]       LAST_BIT   = 4'd11;

   // Position of each button in the received frame (first bit at index 0).
   localparam int BIT_B      = 0;
   localparam int BIT_SELECT = 2;
   localparam int BIT_START  = 3;
   localparam int BIT_UP     = 4;
   localparam int BIT_DOWN   = 5;
   localparam int BIT_LEFT   = 6;
   localparam int BIT_RIGHT  = 7;
   localparam int BIT_A      = 8;
   localparam int BIT_X      = 9;

   state_e           state_q;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [DIV_W-1:0] div_q;
   logic [3:0]       bit_q;
   logic [11:0]      shreg_q;
   logic             pad_latch_q;
   logic             pad_clk_q;
   logic [9:0]       word_q, word_d;
   logic             trigger_q;
   logic             present_q, present_d;
   logic             prev_b_q, prev_b_d;

   logic b_pr, up_pr, down_pr, left_pr, right_pr;
   logic no_pad;

   // ------------------------------------------------------------------
   // Frame counter: free running, independent of the reader state. A wrap
   // that happens while a read is still running is simply missed.
   // ------------------------------------------------------------------
   always_comb begin
      frame_cnt_d = frame_cnt_q + 1'b1;
      if (frame_cnt_q == FRAME_LAST) begin
         frame_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Decode of the completed frame held in shreg_q (raw levels, 0 = pressed).
   // ------------------------------------------------------------------
   always_comb begin
      b_pr     = ~shreg_q[BIT_B];
      up_pr    = ~shreg_q[BIT_UP];
      down_pr  = ~shreg_q[BIT_DOWN];
      left_pr  = ~shreg_q[BIT_LEFT];
      right_pr = ~shreg_q[BIT_RIGHT];
      // A disconnected pad reads as all zeros, which would otherwise look
      // like every button held.
      no_pad   = (shreg_q == 12'd0);

      word_d    = '0;
      present_d = 1'b0;
      prev_b_d  = 1'b0;
      if (!no_pad) begin
         present_d = 1'b1;
         prev_b_d  = b_pr;
         // Opposing directions cancel each other out.
         word_d[9] = b_pr & ~prev_b_q;
         word_d[8] = right_pr & ~left_pr;
         word_d[7] = left_pr & ~right_pr;
         word_d[6] = down_pr & ~up_pr;
         word_d[5] = up_pr & ~down_pr;
         word_d[4] = b_pr;
         word_d[3] = ~shreg_q[BIT_A];
         word_d[2] = ~shreg_q[BIT_START];
         word_d[1] = ~shreg_q[BIT_SELECT];
         word_d[0] = ~shreg_q[BIT_X];
      end
   end

   // ------------------------------------------------------------------
   // Read sequencer. All pad-facing and published outputs are registered here.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         div_q       <= '0;
         bit_q       <= '0;
         shreg_q     <= '0;
         pad_latch_q <= 1'b0;
         pad_clk_q   <= 1'b1;
         word_q      <= '0;
         trigger_q   <= 1'b0;
         present_q   <= 1'b0;
         prev_b_q    <= 1'b0;
      end else begin
         trigger_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (frame_cnt_q == '0) begin
                  state_q     <= ST_LATCH;
                  pad_latch_q <= 1'b1;
                  div_q       <= '0;
               end
            end
            ST_LATCH: begin
               if (div_q == BIT_LAST) begin
                  state_q     <= ST_SHIFT;
                  pad_latch_q <= 1'b0;
                  pad_clk_q   <= 1'b0;
                  div_q       <= '0;
                  bit_q       <= '0;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            ST_SHIFT: begin
               if (div_q == HALF_LAST) begin
                  // Sample on the last low cycle. The pad moves to its next
                  // bit on the rising pad_clk edge issued here.
                  pad_clk_q <= 1'b1;
                  shreg_q   <= {pad_data, shreg_q[11:1]};
                  div_q     <= div_q + 1'b1;
               end else if (div_q == BIT_LAST) begin
                  div_q <= '0;
                  if (bit_q == LAST_BIT) begin
                     // pad_clk stays high. The new frame is published on the
                     // same edge that ends the final high phase.
                     state_q   <= ST_UPDATE;
                     word_q    <= word_d;
                     present_q <= present_d;
                     prev_b_q  <= prev_b_d;
                     trigger_q <= 1'b1;
                  end else begin
                     bit_q     <= bit_q + 1'b1;
                     pad_clk_q <= 1'b0;
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            ST_UPDATE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign pad_latch   = pad_latch_q;
   assign pad_clk     = pad_clk_q;
   assign input_data  = word_q;
   assign trigger     = trigger_q;
   assign pad_present = present_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gamepad_input_encoder.sv
// ---------------------------------------------------------------------------
// tb_gamepad_input_encoder
//
// Drives gamepad_input_encoder (CLK_DIV=2, FRAME_PERIOD=200) from a
// behavioural SNES pad model.
//
// The pad model counts pad_clk rising edges since the latch. It presents the
// raw level of the matching button, or 0 everywhere when the pad is unplugged.
//
// The reference model computes each expected word from the pressed-button set
// with plain arithmetic. The reference model also tracks the previous valid B
// state.
// ---------------------------------------------------------------------------
module tb_gamepad_input_encoder;

   localparam int CLK_DIV      = 2;
   localparam int FRAME_PERIOD = 200;
   localparam int LAT          = 26 * CLK_DIV;   // latch rise -> trigger

   // Button indices in the pad's serial order.
   localparam int BTN_B      = 0;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   localparam int BTN_A      = 8;
   localparam int BTN_X      = 9;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic       pad_data;
   logic       pad_latch;
   logic       pad_clk;
   logic [9:0] input_data;
   logic       trigger;
   logic       pad_present;
   logic [1:0] dbg_state;

   gamepad_input_encoder #(
      .CLK_DIV      (CLK_DIV),
      .FRAME_PERIOD (FRAME_PERIOD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pad_data    (pad_data),
      .pad_latch   (pad_latch),
      .pad_clk     (pad_clk),
      .input_data  (input_data),
      .trigger     (trigger),
      .pad_present (pad_present),
      .dbg_state_o (dbg_state)
   );

   // ---------------- pad model ----------------
   logic [11:0] btn_pressed = 12'd0;   // 1 = pressed
   logic        tie0        = 1'b0;    // pad unplugged, data line reads 0
   logic [4:0]  pad_idx     = 5'd0;

   always @(posedge pad_latch or posedge pad_clk) begin
      if (pad_latch === 1'b1) pad_idx <= 5'd0;
      else if (pad_idx != 5'd31) pad_idx <= pad_idx + 5'd1;
   end

   assign pad_data = tie0 ? 1'b0 :
                     (pad_idx < 5'd12) ? ~btn_pressed[pad_idx[3:0]] : 1'b1;

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;

   logic [9:0] m_word    = 10'd0;
   logic       m_present = 1'b0;
   logic       m_prev_b  = 1'b0;
   int         last_trig_cyc   = 0;
   bit         last_trig_valid = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected {present, word} for one read.
   function automatic logic [10:0] ref_read(input logic [11:0] pressed, input bit unplugged,
                                            input bit prev_b);
      int w;
      w = 0;
      // An all-zero serial frame means no pad, whatever caused it.
      if (unplugged || pressed == 12'hFFF) return 11'd0;
      if (pressed[BTN_X])      w += 1;
      if (pressed[BTN_SELECT]) w += 2;
      if (pressed[BTN_START])  w += 4;
      if (pressed[BTN_A])      w += 8;
      if (pressed[BTN_B])      w += 16;
      if (pressed[BTN_UP] != pressed[BTN_DOWN])
         w += pressed[BTN_UP] ? 32 : 64;
      if (pressed[BTN_LEFT] != pressed[BTN_RIGHT])
         w += pressed[BTN_LEFT] ? 128 : 256;
      if (pressed[BTN_B] && !prev_b) w += 512;
      return {1'b1, w[9:0]};
   endfunction

   // One full read observed cycle by cycle from the negedge where pad_latch
   // is first seen high (c=0). abort_at >= 0 pulls reset at that cycle.
   task automatic run_read(input logic [11:0] pressed, input bit unplugged,
                           input bit check_wave, input int abort_at, output int waited);
      logic [10:0] e;
      bit          exp_latch;
      bit          exp_pclk;
      btn_pressed = pressed;
      tie0        = unplugged;
      waited      = 0;
      while (pad_latch !== 1'b1 && waited < 2 * FRAME_PERIOD) begin
         @(negedge clk);
         waited++;
      end
      if (pad_latch !== 1'b1) begin
         chk("latch_timeout", 32'(pad_latch), 32'd1);
         return;
      end
      e = ref_read(pressed, unplugged, m_prev_b);
      for (int c = 0; c <= LAT + 1; c++) begin
         if (c > 0) @(negedge clk);
         if (c == abort_at) begin
            reset = 1'b0;
            @(negedge clk);
            chk("abort_pad_clk", 32'(pad_clk), 32'd1);
            chk("abort_pad_latch", 32'(pad_latch), 32'd0);
            chk("abort_trigger", 32'(trigger), 32'd0);
            chk("abort_data", 32'(input_data), 32'd0);
            chk("abort_present", 32'(pad_present), 32'd0);
            repeat (LAT) begin
               @(negedge clk);
               chk("abort_no_trigger", 32'(trigger), 32'd0);
            end
            reset           = 1'b1;
            m_word          = 10'd0;
            m_present       = 1'b0;
            m_prev_b        = 1'b0;
            last_trig_valid = 1'b0;
            return;
         end
         if (check_wave) begin
            exp_latch = (c < 2 * CLK_DIV);
            if (c < 2 * CLK_DIV || c >= LAT) exp_pclk = 1'b1;
            else exp_pclk = (((c - 2 * CLK_DIV) % (2 * CLK_DIV)) >= CLK_DIV);
            chk("wave_latch", 32'(pad_latch), 32'(exp_latch));
            chk("wave_pad_clk", 32'(pad_clk), 32'(exp_pclk));
         end
         chk("trigger", 32'(trigger), 32'(c == LAT));
         if (c < LAT) begin
            chk("hold_data", 32'(input_data), 32'(m_word));
            chk("hold_present", 32'(pad_present), 32'(m_present));
         end else begin
            chk("data", 32'(input_data), 32'(e[9:0]));
            chk("present", 32'(pad_present), 32'(e[10]));
         end
         if (c == LAT) begin
            if (last_trig_valid) chk("period", 32'(cyc - last_trig_cyc), 32'(FRAME_PERIOD));
            last_trig_cyc   = cyc;
            last_trig_valid = 1'b1;
         end
      end
      m_word    = e[9:0];
      m_present = e[10];
      m_prev_b  = e[10] & pressed[BTN_B];
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int w;
      logic [11:0] r;
      bit          u;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pad_latch", 32'(pad_latch), 32'd0);
      chk("rst_pad_clk", 32'(pad_clk), 32'd1);
      chk("rst_data", 32'(input_data), 32'd0);
      chk("rst_trigger", 32'(trigger), 32'd0);
      chk("rst_present", 32'(pad_present), 32'd0);
      reset = 1'b1;

      // Right only, with waveform check; then again for the frame period.
      run_read(12'h080, 1'b0, 1'b1, -1, w);
      chk("first_start", 32'(w), 32'd1);
      chk("right_word", 32'(input_data), 32'h100);
      chk("right_present", 32'(pad_present), 32'd1);
      run_read(12'h080, 1'b0, 1'b0, -1, w);

      // B held over two reads, then released.
      run_read(12'h001, 1'b0, 1'b0, -1, w);
      chk("b_first", 32'(input_data), 32'h210);
      run_read(12'h001, 1'b0, 1'b0, -1, w);
      chk("b_held", 32'(input_data), 32'h010);
      run_read(12'h000, 1'b0, 1'b0, -1, w);
      chk("b_released", 32'(input_data), 32'h000);

      // Up+Down+Left: vertical axis cancels, Left remains.
      run_read(12'h070, 1'b0, 1'b0, -1, w);
      chk("opposing", 32'(input_data), 32'h080);

      // No pad clears previous B: press, unplug, press again.
      run_read(12'h001, 1'b0, 1'b0, -1, w);
      run_read(12'h000, 1'b1, 1'b0, -1, w);
      chk("nopad_data", 32'(input_data), 32'h000);
      chk("nopad_present", 32'(pad_present), 32'd0);
      run_read(12'h000, 1'b1, 1'b0, -1, w);
      run_read(12'h001, 1'b0, 1'b0, -1, w);
      chk("b_after_nopad", 32'(input_data), 32'h210);

      // Reset in the middle of bit 5, then a clean restart.
      run_read(12'h001, 1'b0, 1'b0, 2 * CLK_DIV + 5 * 2 * CLK_DIV + 1, w);
      run_read(12'h001, 1'b0, 1'b1, -1, w);
      chk("restart_start", 32'(w), 32'd1);
      chk("restart_word", 32'(input_data), 32'h210);

      // Random button sets, occasionally unplugged.
      for (int i = 0; i < 14; i++) begin
         r = 12'($urandom_range(0, 4095));
         u = ($urandom_range(0, 7) == 0);
         run_read(r, u, 1'b0, -1, w);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gamepad_input_encoder.md
GAMEPAD_INPUT_ENCODER -- requirements
Module: gamepad_input_encoder

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per pad_latch/pad_clk half-phase, minimum 1.
REQ-002 SHALL have parameter FRAME_PERIOD, default 50000: clk cycles between read starts; FRAME_PERIOD > 26*CLK_DIV+2.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port pad_data  in  1  serial button data from SNES-style pad; 0 = pressed.
REQ-006 SHALL have port pad_latch  out  1  parallel-load strobe to pad, active high.
REQ-007 SHALL have port pad_clk  out  1  shift clock to pad, idle high.
REQ-008 SHALL have port input_data  out  10  packed player input word; [9] attack press, [8] right, [7] left, [6] down, [5] up, [4] attack held, [3] A, [2] Start, [1] Select, [0] X.
REQ-009 SHALL have port trigger  out  1  one-cycle frame pulse marking new input_data.
REQ-010 SHALL have port pad_present  out  1  1 = valid pad detected on last read.

Function
REQ-011 SHALL run a free-running frame counter 0..FRAME_PERIOD-1, wrapping to 0; a read starts whenever the counter is 0 and the FSM is IDLE.
REQ-012 SHALL implement FSM states IDLE, LATCH, SHIFT, UPDATE; IDLE->LATCH on counter==0, LATCH->SHIFT after 2*CLK_DIV cycles, SHIFT->UPDATE after 12 bits, UPDATE->IDLE after 1 cycle.
REQ-013 SHALL hold pad_latch high for exactly 2*CLK_DIV cycles in LATCH, low otherwise.
REQ-014 SHALL, per bit in SHIFT, drive pad_clk low CLK_DIV cycles then high CLK_DIV cycles, sampling pad_data on the last low-phase cycle.
REQ-015 SHALL receive bits in order: B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R; Y, L, R are sampled and discarded.
REQ-016 SHALL update input_data, pad_present and assert trigger on the same edge, 26*CLK_DIV cycles after the edge on which pad_latch rose; trigger high exactly one cycle per read.
REQ-017 SHALL hold input_data stable between triggers.
REQ-018 SHALL set input_data[9] = B pressed this read AND B not pressed in the previous valid read; input_data[4] = B pressed.
REQ-019 SHALL report both directions of an opposing pair (Up/Down, Left/Right) as 0 when both are pressed; other axis unaffected.
REQ-020 SHALL treat a read with all 12 sampled bits 0 as no pad: pad_present=0, input_data=0, previous-B cleared, trigger still pulses.
REQ-021 SHALL ignore counter wraps occurring outside IDLE (no queued read).

Reset
REQ-022 SHALL, while reset=0 on a clk edge, set pad_latch=0, pad_clk=1, input_data=0, trigger=0, pad_present=0, previous-B=0, frame counter=0, state IDLE.
REQ-023 SHALL abort any read in progress on reset with no trigger; first read starts on the first edge after reset returns high.

Verification (CLK_DIV=2, FRAME_PERIOD=200)
REQ-024 SHALL verify: reset low 3 cycles -> all outputs at reset values; after release pad_latch high 4 cycles, then 12 pad_clk low/high pulses of 2 cycles each.
REQ-025 SHALL verify: pad drives only Right pressed -> trigger one cycle, 52 cycles after pad_latch rise, input_data=0x100, pad_present=1; next trigger 200 cycles later.
REQ-026 SHALL verify: B pressed on two consecutive reads -> input_data 0x210 then 0x010; released -> 0x000.
REQ-027 SHALL verify: Up+Down+Left pressed -> input_data=0x080.
REQ-028 SHALL verify: pad_data tied 0 -> pad_present=0, input_data=0x000, trigger still every 200 cycles.
REQ-029 SHALL verify: reset asserted mid-SHIFT (bit 5) -> next edge pad_clk=1, pad_latch=0, no trigger; clean read restarts after release.
